multicycle_main_fsm: RTL and testbench
======================================

Name: multicycle_main_fsm

Overview:
- Multi-cycle RV32I main controller FSM.
- Sits directly upstream of the ALU decoder: drives alu_op[1:0] plus the datapath mux selects and write enables for each instruction phase.
- Consumes opcode and funct3 from the instruction register, alu_zero from the ALU, and mem_ready from the unified instruction/data memory.
- alu_op encoding: 00 add, 01 branch compare, 10 R/I-type by funct, 11 JALR address add.

Parameters:
- MEM_WAIT_MAX, 0, maximum cycles spent waiting for mem_ready in FETCH/MEMREAD/MEMWRITE; 0 means unbounded.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- opcode  input  7  IR[6:0].
- funct3  input  3  IR[14:12].
- alu_zero  input  1  ALU zero flag.
- mem_ready  input  1  memory access completes this cycle.
- pc_write  output  1  PC load enable.
- adr_src  output  1  memory address select: 0 PC, 1 ALUOut.
- mem_write  output  1  memory write request.
- ir_write  output  1  IR and oldPC load enable.
- result_src  output  2  result select: 00 ALUOut, 01 ReadData, 10 ALUResult.
- alu_src_a  output  2  ALU A select: 00 PC, 01 oldPC, 10 rs1, 11 zero.
- alu_src_b  output  2  ALU B select: 00 rs2, 01 imm, 10 const 4.
- alu_op  output  2  to ALU decoder.
- reg_write  output  1  register file write enable.
- illegal_instr  output  1  1-cycle pulse, unknown opcode.
- mem_timeout  output  1  1-cycle pulse, wait limit hit.
- retire  output  1  1-cycle pulse, instruction completed.
- state  output  4  current state, for debug.

Behaviour:
- Synchronous reset: rst_n=0 at a rising edge sets state to FETCH (0) and clears the wait counter. This holds mid-instruction; no partial writes persist.
- Moore outputs decoded from state. Exceptions: pc_write/ir_write in FETCH and pc_write in BRANCH use live inputs.
- Every output not listed for a state is 0.
- While rst_n=0, pc_write, ir_write, mem_write, reg_write, retire, illegal_instr and mem_timeout are forced to 0.
- State encoding and per-state outputs:
  - FETCH=0: a=00, b=10, op=00, result_src=10, ir_write=pc_write=mem_ready. Stays in FETCH until mem_ready, then DECODE.
  - DECODE=1: a=01, b=01, op=00 (branch/JAL target into ALUOut). Next state by opcode:
    - 0000011 or 0100011 -> MEMADR.
    - 0110011 -> EXEC_R.
    - 0010011 -> EXEC_I.
    - 1100011 -> BRANCH.
    - 1101111 -> JAL.
    - 1100111 -> JALR_ADR.
    - 0110111 -> LUI.
    - Any other opcode -> FETCH with illegal_instr=1 in DECODE; no retire.
  - MEMADR=2: a=10, b=01, op=00. opcode[5]=0 -> MEMREAD, opcode[5]=1 -> MEMWRITE.
  - MEMREAD=3: adr_src=1. Waits for mem_ready, then MEMWB.
  - MEMWB=4: result_src=01, reg_write=1, retire=1 -> FETCH.
  - MEMWRITE=5: adr_src=1, mem_write=1 held until the mem_ready cycle, then retire=1 -> FETCH.
  - EXEC_R=6: a=10, b=00, op=10 -> ALUWB.
  - EXEC_I=7: a=10, b=01, op=10 -> ALUWB.
  - ALUWB=8: result_src=00, reg_write=1, retire=1 -> FETCH.
  - BRANCH=9: a=10, b=00, op=01, result_src=00, pc_write=alu_zero^funct3[0], retire=1 -> FETCH.
  - JAL=10: a=01, b=10, op=00, result_src=00, pc_write=1 -> ALUWB (rd=oldPC+4).
  - JALR_ADR=11: a=10, b=01, op=11 (rs1+imm overwrites ALUOut) -> JAL.
  - LUI=12: a=11, b=01, op=00 -> ALUWB.
  - Codes 13-15 are unreachable; if entered, go to FETCH with all outputs 0.
- Latency with mem_ready=1, counting FETCH through retire: branch 3; R/I/LUI/sw/jal 4; lw/jalr 5. Each mem_ready-low cycle adds 1.
- Wait counter: increments each cycle in a wait state with mem_ready=0 and clears on any state change. If MEM_WAIT_MAX>0 and the count reaches MEM_WAIT_MAX with mem_ready still 0: mem_timeout=1 that cycle, next state FETCH, and no pc_write/ir_write/reg_write.
- mem_ready and timeout in the same cycle: mem_ready wins.
- mem_ready outside wait states is ignored.

Test Plan:
- Reset then add (0110011), mem_ready=1 -> states 0,1,6,8,0; alu_op=10 in state 6; reg_write=1 and retire=1 only in state 8; 4 cycles.
- lw with mem_ready low for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4; adr_src=1 in state 3; reg_write with result_src=01 in state 4.
- beq with alu_zero=1, then bne with alu_zero=1 -> pc_write=1 in BRANCH for the beq, pc_write=0 for the bne; alu_op=01 both times.
- jalr -> states 0,1,11,10,8; alu_op=11 in state 11; pc_write=1 in state 10; reg_write=1 in state 8.
- Opcode 0000000 -> illegal_instr pulse in DECODE, next state FETCH, no retire, no reg_write. Separately, MEM_WAIT_MAX=3 with mem_ready held low in FETCH -> mem_timeout at the 3rd wait cycle, state stays 0, no ir_write.
- rst_n low during MEMWRITE with mem_ready=0 -> mem_write=0 that cycle, state=0 next cycle, wait counter cleared.

Source files
------------

// File: rtl/multicycle_main_fsm.sv
// Multi-cycle RV32I main controller: sequences fetch/decode/execute/memory/writeback
// phases and drives datapath selects, write enables and alu_op for the ALU decoder.
module multicycle_main_fsm #(
  parameter int unsigned MEM_WAIT_MAX = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       illegal_instr,
  output logic       mem_timeout,
  output logic       retire,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR_ADR = 4'd11,
    LUI      = 4'd12
  } state_t;

  localparam int unsigned CW = $clog2(MEM_WAIT_MAX + 2);
  // Counter holds the number of earlier stalled cycles, so the limit is hit on
  // the MEM_WAIT_MAX-th consecutive stalled cycle.
  localparam logic [CW-1:0] LIMIT = CW'(MEM_WAIT_MAX > 0 ? MEM_WAIT_MAX - 1 : 0);

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt;
  logic          wait_st, stall, timeout;
  logic          unused_funct3;

  assign unused_funct3 = ^funct3[2:1];
  assign state   = state_q;
  assign wait_st = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
  assign stall   = wait_st && !mem_ready;
  assign timeout = (MEM_WAIT_MAX != 0) && stall && (wait_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (stall && !timeout)
        wait_cnt <= (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;
    mem_timeout   = 1'b0;
    retire        = 1'b0;

    case (state_q)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          7'b0000011, 7'b0100011: state_d = MEMADR;
          7'b0110011:             state_d = EXEC_R;
          7'b0010011:             state_d = EXEC_I;
          7'b1100011:             state_d = BRANCH;
          7'b1101111:             state_d = JAL;
          7'b1100111:             state_d = JALR_ADR;
          7'b0110111:             state_d = LUI;
          default: begin
            state_d       = FETCH;
            illegal_instr = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = opcode[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = mem_ready;
        if (mem_ready) state_d = FETCH;
      end
      EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = alu_zero ^ funct3[0];
        retire    = 1'b1;
        state_d   = FETCH;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = ALUWB;
      end
      JALR_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
        state_d   = JAL;
      end
      LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        state_d   = ALUWB;
      end
      default: state_d = FETCH;
    endcase

    // Stall limit reached: abandon the access; enables are already low since mem_ready=0.
    if (timeout) begin
      mem_timeout = 1'b1;
      state_d     = FETCH;
    end

    if (!rst_n) begin
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      retire        = 1'b0;
      illegal_instr = 1'b0;
      mem_timeout   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Bench for multicycle_main_fsm: directed scenarios then random instructions, memory
// stalls and resets, checked against an instruction-path reference model.
module tb_multicycle_main_fsm;

  logic       clk = 1'b0;
  logic       rst_n, alu_zero, mem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic       illegal_instr, mem_timeout, retire;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0] state;
  logic [15:0] outs;

  always #5 clk = ~clk;

  multicycle_main_fsm #(.MEM_WAIT_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .pc_write(pc_write),
    .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .illegal_instr(illegal_instr),
    .mem_timeout(mem_timeout), .retire(retire), .state(state)
  );

  assign outs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                 alu_src_b, alu_op, reg_write, illegal_instr, mem_timeout, retire};

  int unsigned n_vec = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: each instruction is a list of phases; stalls repeat the head phase.
  int         path[$];
  logic [9:0] dir_q[$];
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  bit         cur_dir;
  int         m_wait;
  int         stall_fetch, stall_rd;
  bit         rst_wr;

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37};
  endfunction

  task automatic new_instr();
    logic [9:0] e;
    int k;
    if (dir_q.size() > 0) begin
      e = dir_q.pop_front();
      cur_f3 = e[9:7];
      cur_op = e[6:0];
      cur_dir = 1'b1;
    end else begin
      k = $urandom_range(0, 9);
      cur_f3 = 3'($urandom);
      cur_dir = 1'b0;
      case (k)
        0: cur_op = 7'h03;
        1: cur_op = 7'h23;
        2: cur_op = 7'h33;
        3: cur_op = 7'h13;
        4: cur_op = 7'h63;
        5: cur_op = 7'h6F;
        6: cur_op = 7'h67;
        7: cur_op = 7'h37;
        8: cur_op = 7'h00;
        default: cur_op = 7'($urandom);
      endcase
    end
    case (cur_op)
      7'h03: path = {0, 1, 2, 3, 4};
      7'h23: path = {0, 1, 2, 5};
      7'h33: path = {0, 1, 6, 8};
      7'h13: path = {0, 1, 7, 8};
      7'h63: path = {0, 1, 9};
      7'h6F: path = {0, 1, 10, 8};
      7'h67: path = {0, 1, 11, 10, 8};
      7'h37: path = {0, 1, 12, 8};
      default: path = {0, 1};
    endcase
  endtask

  function automatic logic [15:0] exp_out(input int s, input logic mr, input logic az,
                                          input logic f3_0, input logic ill,
                                          input logic to, input logic r);
    logic pc, adr, mw, irw, rw, il, ret, tov;
    logic [1:0] res, a, b, op;
    {pc, adr, mw, irw, rw, il, ret} = '0;
    {res, a, b, op} = '0;
    tov = to;
    case (s)
      0:  begin b = 2'b10; res = 2'b10; irw = mr; pc = mr; end
      1:  begin a = 2'b01; b = 2'b01; il = ill; end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  adr = 1'b1;
      4:  begin res = 2'b01; rw = 1'b1; ret = 1'b1; end
      5:  begin adr = 1'b1; mw = 1'b1; ret = mr; end
      6:  begin a = 2'b10; op = 2'b10; end
      7:  begin a = 2'b10; b = 2'b01; op = 2'b10; end
      8:  begin rw = 1'b1; ret = 1'b1; end
      9:  begin a = 2'b10; op = 2'b01; pc = az ^ f3_0; ret = 1'b1; end
      10: begin a = 2'b01; b = 2'b10; pc = 1'b1; end
      11: begin a = 2'b10; b = 2'b01; op = 2'b11; end
      12: begin a = 2'b11; b = 2'b01; end
      default: ;
    endcase
    if (!r) {pc, mw, irw, rw, ret, il, tov} = '0;
    return {pc, adr, mw, irw, res, a, b, op, rw, il, tov, ret};
  endfunction

  task automatic cycle(input logic r, input logic mr, input logic az);
    int s;
    bit wait_s, to;
    logic [15:0] e;
    @(negedge clk);
    rst_n = r; mem_ready = mr; alu_zero = az; opcode = cur_op; funct3 = cur_f3;
    #1;
    s = path[0];
    wait_s = (s == 0) || (s == 3) || (s == 5);
    to = r && wait_s && !mr && (m_wait + 1 == 3);
    e = exp_out(s, mr, az, cur_f3[0], !is_legal(cur_op), to, r);
    check("state", {28'd0, state}, 32'(s));
    check($sformatf("outs@s%0d", s), {16'd0, outs}, {16'd0, e});
    if (!r) begin
      m_wait = 0;
      new_instr();
    end else if (wait_s && !mr) begin
      if (to) begin
        m_wait = 0;
        if (s != 0) new_instr();
      end else begin
        m_wait++;
      end
    end else begin
      void'(path.pop_front());
      m_wait = 0;
      if (path.size() == 0) new_instr();
    end
  endtask

  initial begin
    logic r, mr, az;
    int guard;
    rst_n = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0; opcode = '0; funct3 = '0;
    repeat (2) @(negedge clk);

    // add, lw, beq, bne, jalr, illegal, sw
    dir_q = {{3'd0, 7'h33}, {3'd2, 7'h03}, {3'd0, 7'h63}, {3'd1, 7'h63},
             {3'd0, 7'h67}, {3'd0, 7'h00}, {3'd2, 7'h23}};
    stall_fetch = 3;
    stall_rd = 2;
    rst_wr = 1'b1;
    m_wait = 0;
    new_instr();

    guard = 0;
    while (cur_dir && guard < 200) begin
      r = 1'b1; mr = 1'b1; az = 1'b1;
      if (path[0] == 0 && stall_fetch > 0) begin mr = 1'b0; stall_fetch--; end
      if (path[0] == 3 && stall_rd > 0) begin mr = 1'b0; stall_rd--; end
      if (path[0] == 5 && rst_wr) begin mr = 1'b0; r = 1'b0; rst_wr = 1'b0; end
      cycle(r, mr, az);
      guard++;
    end
    check("directed_done", {31'd0, cur_dir}, 32'd0);

    repeat (1500) begin
      r  = ($urandom_range(0, 99) != 0);
      mr = ($urandom_range(0, 3) != 0);
      az = 1'($urandom_range(0, 1));
      cycle(r, mr, az);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
